// File: rtl/gelato_types.sv
// ============================================================================
// Module      : gelato_types (package)
// Description : Shared GPU pipeline types: addresses, warp ids, thread masks,
//               instruction words and the instruction-buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gelato_types;

    localparam int c_addr_width   = 32;
    localparam int c_warp_width   = 3;
    localparam int c_thread_width = 32;
    localparam int c_inst_width   = 32;

    typedef logic [c_addr_width-1:0]   addr_t;
    typedef logic [c_warp_width-1:0]   warp_num_t;
    typedef logic [c_thread_width-1:0] thread_mask_t;
    typedef logic [c_inst_width-1:0]   inst_t;

    // Default number of entries in each per-warp instruction FIFO
    localparam int IBUF_DEPTH = 2;

    typedef struct packed {
        addr_t        pc;
        thread_mask_t thread_mask;
        inst_t        inst;
    } ibuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/gelato_idecode_ibuffer_if.sv
// ============================================================================
// Module      : gelato_idecode_ibuffer_if
// Description : I-Decode to instruction-buffer write channel. No back-pressure
//               wire: the producer watches the per-warp full flags instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gelato_idecode_ibuffer_if;
    import gelato_types::*;

    logic         valid;
    addr_t        pc;
    warp_num_t    warp_num;
    thread_mask_t thread_mask;
    inst_t        inst;

    modport master (output valid, pc, warp_num, thread_mask, inst);
    modport slave  (input  valid, pc, warp_num, thread_mask, inst);

endinterface

`default_nettype wire

// File: rtl/gelato_ibuffer_fifo.sv
// ============================================================================
// Module      : gelato_ibuffer_fifo
// Description : Single-warp decoded-instruction FIFO. Push and pop may occur
//               together at full; flush clears pointers and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gelato_ibuffer_fifo
    import gelato_types::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  ibuf_entry_t i_wdata,
    output ibuf_entry_t o_rdata,
    output logic        o_full,
    output logic        o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_cnt_w-1:0] r_count;
    ibuf_entry_t        r_mem [DEPTH];

    // Pointer and occupancy bookkeeping; flush wins over any same-cycle push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + c_ptr_w'(1);
            if (i_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
            if (i_push && !i_pop)
                r_count <= r_count + c_cnt_w'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - c_cnt_w'(1);
        end
    end

    // Entry storage; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/gelato_ibuffer.sv
// ============================================================================
// Module      : gelato_ibuffer
// Description : Per-warp decoded-instruction buffer with round-robin issue
//               arbiter and offer lock. Optional sticky overflow detection is
//               enabled by defining GELATO_IBUFFER_OVERFLOW_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gelato_ibuffer
    import gelato_types::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int DEPTH     = IBUF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    gelato_idecode_ibuffer_if.slave        idecode,
    output logic [NUM_WARPS-1:0]           ibuf_full,
    output logic [NUM_WARPS-1:0]           ibuf_empty,
    input  logic [NUM_WARPS-1:0]           warp_stall,
    input  logic                           flush_valid,
    input  warp_num_t                      flush_warp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output addr_t                          out_pc,
    output warp_num_t                      out_warp_num,
    output thread_mask_t                   out_thread_mask,
    output inst_t                          out_inst,
    output logic                           overflow_err
);

    warp_num_t            r_rr_ptr;
    warp_num_t            r_lock_warp;
    logic                 r_lock_vld;

    ibuf_entry_t          w_head [NUM_WARPS];
    ibuf_entry_t          w_wdata;
    logic [NUM_WARPS-1:0] w_push;
    logic [NUM_WARPS-1:0] w_pop;
    logic [NUM_WARPS-1:0] w_flush;
    logic [NUM_WARPS-1:0] w_elig;
    warp_num_t            w_rr_sel;
    warp_num_t            w_cand;
    warp_num_t            w_sel;
    logic                 w_found;
    logic                 w_lock_flushed;
    logic                 w_hs;

    assign w_wdata = '{pc: idecode.pc, thread_mask: idecode.thread_mask, inst: idecode.inst};

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            assign w_flush[gi] = flush_valid && (flush_warp == warp_num_t'(gi));
            assign w_pop[gi]   = w_hs && (w_sel == warp_num_t'(gi));
            // A full FIFO still takes the write when its head leaves this cycle
            assign w_push[gi]  = idecode.valid && (idecode.warp_num == warp_num_t'(gi))
                                 && !w_flush[gi] && (!ibuf_full[gi] || w_pop[gi]);
            assign w_elig[gi]  = !ibuf_empty[gi] && !warp_stall[gi] && !w_flush[gi];

            gelato_ibuffer_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_flush (w_flush[gi]),
                .i_wdata (w_wdata),
                .o_rdata (w_head[gi]),
                .o_full  (ibuf_full[gi]),
                .o_empty (ibuf_empty[gi])
            );
        end
    endgenerate

    // Round-robin search for the first eligible warp at or after r_rr_ptr
    always_comb begin
        w_found  = 1'b0;
        w_rr_sel = r_rr_ptr;
        w_cand   = r_rr_ptr;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_cand = r_rr_ptr + warp_num_t'(i);
            if (!w_found && w_elig[w_cand]) begin
                w_found  = 1'b1;
                w_rr_sel = w_cand;
            end
        end
    end

    // A locked offer ignores stall; only flushing that warp withdraws it
    assign w_sel          = r_lock_vld ? r_lock_warp : w_rr_sel;
    assign w_lock_flushed = r_lock_vld && w_flush[r_lock_warp];
    assign out_valid      = r_lock_vld ? !w_lock_flushed : w_found;
    assign w_hs           = out_valid && out_ready;

    assign out_pc          = w_head[w_sel].pc;
    assign out_thread_mask = w_head[w_sel].thread_mask;
    assign out_inst        = w_head[w_sel].inst;
    assign out_warp_num    = w_sel;

    // Arbiter pointer advance and offer lock hold/release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_lock_vld  <= 1'b0;
            r_lock_warp <= '0;
        end else begin
            if (w_hs) r_rr_ptr <= w_sel + warp_num_t'(1);
            if (w_hs || w_lock_flushed) begin
                r_lock_vld <= 1'b0;
            end else if (out_valid && !out_ready) begin
                r_lock_vld  <= 1'b1;
                r_lock_warp <= w_sel;
            end
        end
    end

`ifdef GELATO_IBUFFER_OVERFLOW_CHECK_EN
    logic w_drop;
    logic r_overflow_err;

    assign w_drop = idecode.valid && ibuf_full[idecode.warp_num]
                    && !w_pop[idecode.warp_num] && !w_flush[idecode.warp_num];

    // Sticky record of any write lost to a full FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overflow_err <= 1'b0;
        else if (w_drop)
            r_overflow_err <= 1'b1;
    end

    assign overflow_err = r_overflow_err;

`ifndef SYNTHESIS
    a_no_dropped_write: assert property (@(posedge clk) disable iff (rst) !w_drop)
        else $error("gelato_ibuffer: write to full warp %0d dropped", idecode.warp_num);
`endif
`else
    assign overflow_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gelato_ibuffer.sv
// ============================================================================
// Module      : tb_gelato_ibuffer
// Description : Self-checking bench for gelato_ibuffer: directed scenarios and
//               a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gelato_ibuffer;
    import gelato_types::*;

    localparam int NW = 8;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] ibuf_full, ibuf_empty, warp_stall;
    logic          flush_valid;
    warp_num_t     flush_warp;
    logic          out_valid, out_ready;
    addr_t         out_pc;
    warp_num_t     out_warp_num;
    thread_mask_t  out_thread_mask;
    inst_t         out_inst;
    logic          overflow_err;

    gelato_idecode_ibuffer_if idec ();

    always #5 clk = ~clk;

    gelato_ibuffer #(.NUM_WARPS(NW), .DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .idecode         (idec.slave),
        .ibuf_full       (ibuf_full),
        .ibuf_empty      (ibuf_empty),
        .warp_stall      (warp_stall),
        .flush_valid     (flush_valid),
        .flush_warp      (flush_warp),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_warp_num    (out_warp_num),
        .out_thread_mask (out_thread_mask),
        .out_inst        (out_inst),
        .overflow_err    (overflow_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per warp plus arbiter/lock bookkeeping
    ibuf_entry_t mq [NW][$];
    int          m_rr;
    bit          m_lock;
    int          m_lock_w;
    bit          m_ovf;
    bit          e_valid;
    int          e_warp;

    function automatic void model_reset();
        for (int i = 0; i < NW; i++) mq[i].delete();
        m_rr = 0; m_lock = 0; m_lock_w = 0; m_ovf = 0;
    endfunction

    function automatic void predict();
        e_valid = 0;
        e_warp  = 0;
        if (m_lock) begin
            e_warp  = m_lock_w;
            e_valid = !(flush_valid && int'(flush_warp) == m_lock_w);
        end else begin
            for (int i = 0; i < NW; i++) begin
                int w;
                w = (m_rr + i) % NW;
                if (!e_valid && mq[w].size() > 0 && !warp_stall[w]
                    && !(flush_valid && int'(flush_warp) == w)) begin
                    e_valid = 1;
                    e_warp  = w;
                end
            end
        end
    endfunction

    task automatic set_idle();
        idec.valid = 0; idec.pc = '0; idec.warp_num = '0;
        idec.thread_mask = '0; idec.inst = '0;
        warp_stall = '0; flush_valid = 0; flush_warp = '0; out_ready = 0;
    endtask

    task automatic write(input int w, input addr_t pc);
        idec.valid       = 1;
        idec.warp_num    = warp_num_t'(w);
        idec.pc          = pc;
        idec.thread_mask = thread_mask_t'($urandom);
        idec.inst        = inst_t'($urandom);
    endtask

    // Advance one clock and update the model with what that edge did
    task automatic tick();
        bit          hs;
        ibuf_entry_t ent;
        int          w;
        predict();
        @(posedge clk);
        hs = e_valid && out_ready;
        if (hs) void'(mq[e_warp].pop_front());
        if (idec.valid) begin
            w   = int'(idec.warp_num);
            ent = '{pc: idec.pc, thread_mask: idec.thread_mask, inst: idec.inst};
            if (flush_valid && int'(flush_warp) == w) begin
            end else if (mq[w].size() < D) mq[w].push_back(ent);
            else m_ovf = 1;
        end
        if (flush_valid) mq[int'(flush_warp)].delete();
        if (hs) m_rr = (e_warp + 1) % NW;
        if (hs || (m_lock && flush_valid && int'(flush_warp) == m_lock_w)) m_lock = 0;
        else if (e_valid && !out_ready) begin
            m_lock   = 1;
            m_lock_w = e_warp;
        end
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_tests++; if (ibuf_empty !== {NW{1'b1}}) begin n_fail++; $display("FAIL reset_empty got %b exp all ones", ibuf_empty); end
        n_tests++; if (ibuf_full !== '0) begin n_fail++; $display("FAIL reset_full got %b exp 0", ibuf_full); end
        n_tests++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow_err); end
    endtask

    task automatic test_single_write();
        do_reset();
        out_ready = 1;
        write(3, 32'h100);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b exp 0", out_valid); end
        tick();
        idec.valid = 0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_warp_num !== 3'd3 || out_pc !== 32'h100) begin
            n_fail++; $display("FAIL single_offer got v=%b w=%0d pc=%h exp v=1 w=3 pc=100", out_valid, out_warp_num, out_pc); end
        n_tests++; if (ibuf_empty[3] !== 1'b0) begin n_fail++; $display("FAIL single_empty_before got %b exp 0", ibuf_empty[3]); end
        tick();
        n_tests++; if (ibuf_empty[3] !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drained got empty=%b v=%b exp 1 0", ibuf_empty[3], out_valid); end
    endtask

    task automatic test_round_robin();
        int order1 [3] = '{0, 2, 5};
        int order2 [2] = '{0, 2};
        do_reset();
        write(0, 32'h10); tick();
        write(2, 32'h20); tick();
        write(5, 32'h50); tick();
        idec.valid = 0;
        out_ready  = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (out_valid !== 1'b1 || int'(out_warp_num) != order1[k]) begin
                n_fail++; $display("FAIL rr_order[%0d] got v=%b w=%0d exp w=%0d", k, out_valid, out_warp_num, order1[k]); end
            tick();
        end
        out_ready = 0;
        write(0, 32'h11); tick();
        write(2, 32'h21); tick();
        idec.valid = 0;
        out_ready  = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++; if (out_valid !== 1'b1 || int'(out_warp_num) != order2[k]) begin
                n_fail++; $display("FAIL rr_wrap[%0d] got v=%b w=%0d exp w=%0d", k, out_valid, out_warp_num, order2[k]); end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        write(1, 32'hA0); tick();
        n_tests++; if (ibuf_full[1] !== 1'b0) begin n_fail++; $display("FAIL full_after1 got %b exp 0", ibuf_full[1]); end
        write(1, 32'hB0); tick();
        n_tests++; if (ibuf_full[1] !== 1'b1) begin n_fail++; $display("FAIL full_after2 got %b exp 1", ibuf_full[1]); end
        write(1, 32'hC0); tick();
        idec.valid = 0;
`ifdef GELATO_IBUFFER_OVERFLOW_CHECK_EN
        n_tests++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b exp 1", overflow_err); end
`else
        n_tests++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL full_ovf got %b exp 0", overflow_err); end
`endif
        out_ready = 1;
        #1;
        n_tests++; if (out_pc !== 32'hA0) begin n_fail++; $display("FAIL full_head0 got %h exp a0", out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hB0) begin n_fail++; $display("FAIL full_head1 got v=%b pc=%h exp 1 b0", out_valid, out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_dropped got v=%b pc=%h exp v=0", out_valid, out_pc); end
    endtask

    task automatic test_full_issue();
        do_reset();
        write(1, 32'hA1); tick();
        write(1, 32'hB1); tick();
        out_ready = 1;
        write(1, 32'hC1);
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hA1) begin n_fail++; $display("FAIL fi_head got v=%b pc=%h exp 1 a1", out_valid, out_pc); end
        tick();
        idec.valid = 0;
        n_tests++; if (ibuf_full[1] !== 1'b1 || out_pc !== 32'hB1) begin
            n_fail++; $display("FAIL fi_count got full=%b pc=%h exp 1 b1", ibuf_full[1], out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hC1) begin n_fail++; $display("FAIL fi_accepted got v=%b pc=%h exp 1 c1", out_valid, out_pc); end
        tick();
        n_tests++; if (ibuf_empty[1] !== 1'b1) begin n_fail++; $display("FAIL fi_drain got %b exp 1", ibuf_empty[1]); end
    endtask

    task automatic test_lock();
        do_reset();
        write(4, 32'h400); tick();
        idec.valid = 0;
        n_tests++; if (out_valid !== 1'b1 || out_warp_num !== 3'd4) begin
            n_fail++; $display("FAIL lock_offer got v=%b w=%0d exp 1 4", out_valid, out_warp_num); end
        tick();
        warp_stall[4] = 1;
        write(2, 32'h200);
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_warp_num !== 3'd4 || out_pc !== 32'h400) begin
            n_fail++; $display("FAIL lock_hold0 got v=%b w=%0d pc=%h exp 1 4 400", out_valid, out_warp_num, out_pc); end
        tick();
        idec.valid = 0;
        n_tests++; if (out_valid !== 1'b1 || out_warp_num !== 3'd4 || out_pc !== 32'h400) begin
            n_fail++; $display("FAIL lock_hold1 got v=%b w=%0d pc=%h exp 1 4 400", out_valid, out_warp_num, out_pc); end
        out_ready = 1;
        tick();
        n_tests++; if (dut.r_rr_ptr !== 3'd5) begin n_fail++; $display("FAIL lock_rr got %0d exp 5", dut.r_rr_ptr); end
        n_tests++; if (out_valid !== 1'b1 || out_warp_num !== 3'd2) begin
            n_fail++; $display("FAIL lock_next got v=%b w=%0d exp 1 2", out_valid, out_warp_num); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        write(6, 32'h600); tick();
        idec.valid = 0;
        tick();
        flush_valid = 1;
        flush_warp  = 3'd6;
        write(6, 32'h601);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_withdraw got %b exp 0", out_valid); end
        tick();
        idec.valid  = 0;
        flush_valid = 0;
        #1;
        n_tests++; if (ibuf_empty[6] !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty got empty=%b v=%b exp 1 0", ibuf_empty[6], out_valid); end
    endtask

    task automatic test_random();
        logic [NW-1:0] ef, ee;
        int            w;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_idle();
            if ($urandom_range(0, 3) != 0) begin
                w = $urandom_range(0, NW - 1);
                if (mq[w].size() < D) write(w, addr_t'($urandom));
            end
            for (int i = 0; i < NW; i++) warp_stall[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                flush_valid = 1;
                flush_warp  = warp_num_t'($urandom_range(0, NW - 1));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            predict();
            for (int i = 0; i < NW; i++) begin
                ef[i] = (mq[i].size() == D);
                ee[i] = (mq[i].size() == 0);
            end
            n_tests++; if (out_valid !== e_valid) begin
                n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, out_valid, e_valid); end
            if (e_valid) begin
                n_tests++; if (int'(out_warp_num) != e_warp || out_pc !== mq[e_warp][0].pc
                               || out_thread_mask !== mq[e_warp][0].thread_mask || out_inst !== mq[e_warp][0].inst) begin
                    n_fail++; $display("FAIL rnd_data cyc %0d got w=%0d pc=%h exp w=%0d pc=%h", c, out_warp_num, out_pc, e_warp, mq[e_warp][0].pc); end
            end
            n_tests++; if (ibuf_full !== ef || ibuf_empty !== ee) begin
                n_fail++; $display("FAIL rnd_flags cyc %0d got full=%b empty=%b exp %b %b", c, ibuf_full, ibuf_empty, ef, ee); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        write(1, 32'h111); tick();
        write(3, 32'h333); tick();
        idec.valid = 0;
        #2;
        rst = 1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || ibuf_empty !== {NW{1'b1}} || ibuf_full !== '0 || overflow_err !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got v=%b empty=%b full=%b ovf=%b", out_valid, ibuf_empty, ibuf_full, overflow_err); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1;
        set_idle();
        model_reset();
        test_reset();
        @(posedge clk);
        #1;
        rst = 0;
        test_single_write();
        test_round_robin();
        test_full();
        test_full_issue();
        test_lock();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gelato_ibuffer.md
# gelato_ibuffer

Per-warp decoded-instruction buffer and issue scheduler. It sits between I-Decode and the issue/operand stage and is fed by the `gelato_idecode_ibuffer_if` slave modport. Each decoded instruction is stored in a small FIFO for its warp. A round-robin arbiter picks one non-stalled warp with a buffered instruction per cycle and presents its head instruction downstream under a valid/ready handshake.

## Interface
Parameters:
- `NUM_WARPS`, default 8: warp count; must equal 2**$bits(warp_num_t).
- `DEPTH`, default 2: entries per warp FIFO; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `idecode`  slave modport  —  carries `valid`, `pc`, `warp_num`, `thread_mask` and `inst`. There is no ready signal; the producer must honour `ibuf_full`.
- `ibuf_full`  out  NUM_WARPS  per-warp "FIFO holds DEPTH entries"; used by fetch scheduling.
- `ibuf_empty`  out  NUM_WARPS  per-warp "FIFO holds 0 entries".
- `warp_stall`  in  NUM_WARPS  scoreboard/barrier stall mask; a stalled warp is not eligible for a new selection.
- `flush_valid`  in  1  discard all entries of `flush_warp`.
- `flush_warp`  in  warp_num_t  warp to flush.
- `out_valid`  out  1  an instruction is offered downstream.
- `out_ready`  in  1  downstream accepts it.
- `out_pc`, `out_warp_num`, `out_thread_mask`, `out_inst`  out  addr_t / warp_num_t / thread_mask_t / inst_t  the offered instruction.
- `overflow_err`  out  1  sticky overflow flag (see Configuration).

## Operation
- **Write.**
  - When `idecode.valid` is high, the entry {pc, thread_mask, inst} is pushed into FIFO[`warp_num`].
  - If that FIFO is full and the same warp is not issued in the same cycle, the write is dropped.
  - If it is full and the same warp is issued in the same cycle, the write is accepted and the count stays DEPTH.
- **Eligibility.** A warp is eligible when its count is greater than 0, its `warp_stall` bit is low, and it is not being flushed this cycle.
- **Arbitration.**
  - Round-robin search starts at `rr_ptr` and wraps modulo NUM_WARPS.
  - `rr_ptr` resets to 0. On each handshake (`out_valid` and `out_ready` both high) it becomes the issued warp + 1, wrapping from NUM_WARPS-1 to 0.
- **Lock.**
  - Once `out_valid` is high and `out_ready` is low, the selected warp is latched in `lock_vld`/`lock_warp`.
  - Outputs stay unchanged until the handshake completes, even if `warp_stall` for that warp rises.
  - The lock is released by a handshake, or by a flush of the locked warp. A flush of the locked warp deasserts `out_valid` that cycle, so its instruction is withdrawn.
- **Flush.**
  - Sets FIFO[`flush_warp`] count, read pointer and write pointer to 0.
  - A same-cycle write to the same warp is also discarded.
  - Writes to other warps in the same cycle are unaffected.
- **Counts.** Per-warp count is clog2(DEPTH+1) bits wide. Each cycle, count = count + write_accepted − issued; the count never leaves the range 0..DEPTH. Read and write pointers are clog2(DEPTH) bits and wrap naturally.

## Timing
- Write-to-issue latency: an instruction written in cycle N can be offered in cycle N+1 at the earliest; there is no bypass.
- `out_*` are combinational from FIFO heads and the arbiter/lock state, with no combinational path from `out_ready`.
- `ibuf_full`/`ibuf_empty` are derived from registered counts; they reflect writes one cycle later.
- Sustained throughput is one issue per cycle.
- Reset values: all counts, pointers, `rr_ptr`, `lock_vld` and `overflow_err` are 0. Therefore `out_valid`=0, `ibuf_empty`=all ones and `ibuf_full`=0.
- Reset asserted mid-operation discards all buffered instructions immediately. The contents of the data arrays are don't-care.

## Configuration
- `GELATO_IBUFFER_OVERFLOW_CHECK_EN` defined:
  - `overflow_err` is set, and stays set until reset, when a write is dropped because its FIFO is full.
  - A simulation-only assertion also fires on that dropped write.
- Not defined: `overflow_err` is tied to 0, the dropped write is silent, and no flag register exists.

## Structure
- Shared package `gelato_types` gains:
  - `ibuf_entry_t`, a packed struct of {addr_t pc; thread_mask_t thread_mask; inst_t inst}.
  - `IBUF_DEPTH`, the default depth constant.
- Sub-module `gelato_ibuffer_fifo`, one instance per warp, generated:
  - Contents: storage, pointers, count, push/pop/flush, full/empty.
- Arbiter, lock and overflow logic stay in the top level.

## Test plan
- **Single write.** Write warp 3, pc 0x100, with `out_ready`=1. Expect `out_valid` in the next cycle with `out_warp_num`=3 and `out_pc`=0x100, after which `ibuf_empty[3]` returns to 1.
- **Round-robin.**
  - Stimulus: fill warps 0, 2 and 5 with one entry each; hold `out_ready`=1.
  - Expected: issue order 0, 2, 5.
  - Then refill warp 0 and warp 2. Expected: warp 0 is issued after warp 5, because the search wraps around.
- **Full on a plain write.** With DEPTH=2, write warp 1 three times while `out_ready`=0. Expect `ibuf_full[1]`=1 after the second write, the third write dropped, and `overflow_err`=1 when the macro is defined.
- **Full with simultaneous issue.** Warp 1 is full and issuing; a write to warp 1 in the same cycle is accepted and the count stays 2.
- **Lock.**
  - Stimulus: offer warp 4 with `out_ready`=0; raise `warp_stall[4]`. Expected: outputs hold.
  - Then assert `out_ready`. Expected: warp 4 issues and `rr_ptr` becomes 5.
- **Flush.**
  - Stimulus: warp 6 is locked; apply `flush_warp`=6 together with a write to warp 6.
  - Expected: `out_valid` drops in that cycle and `ibuf_empty[6]`=1 in the next cycle.
- **Reset.** Assert `rst` while warps hold entries. Expect all outputs to go to their reset values with no clock edge required.
